// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared definitions for the sequential unsigned divider.
//   - state_e            : FSM state encoding (IDLE / CALC / DONE)
//   - DEF_DIVIDEND_W     : default dividend / quotient width
//   - DEF_DIVISOR_W      : default divisor / remainder width
//   - cnt_width()        : width of the step counter, clog2(DIVIDEND_W+1)
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DEF_DIVIDEND_W = 16;
    localparam int DEF_DIVISOR_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter must be able to hold the value DIVIDEND_W.
    function automatic int cnt_width(input int dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring shift-subtract step.
//   The partial remainder is shifted left and the next dividend bit is appended.
//   If the result is >= divisor, the divisor is subtracted and the quotient bit
//   is 1; otherwise the shifted value is kept and the quotient bit is 0.
//
// Ports
//   pr       in   DIVISOR_W+1  current partial remainder
//   din      in   1            next dividend bit (MSB-first)
//   divisor  in   DIVISOR_W    divisor
//   pr_next  out  DIVISOR_W+1  partial remainder after this step
//   q_bit    out  1            quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int DIVISOR_W = 8
) (
    input  logic [DIVISOR_W:0]   pr,
    input  logic                 din,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   pr_next,
    output logic                 q_bit
);

    // The full shifted value keeps the top bit of pr so the comparison is exact
    // even when pr has grown past DIVISOR_W bits (only possible with divisor 0,
    // where the top bit is dropped on truncation exactly as a plain shift would).
    logic [DIVISOR_W+1:0] shifted;
    logic [DIVISOR_W:0]   diff;
    logic                 ge;

    always_comb begin
        shifted = {pr, din};
        ge      = (shifted >= {2'b00, divisor});
        diff    = shifted[DIVISOR_W:0] - {1'b0, divisor};
        pr_next = ge ? diff : shifted[DIVISOR_W:0];
        q_bit   = ge;
    end

endmodule

// File: rtl/sequential_unsigned_divider.sv
// -----------------------------------------------------------------------------
// sequential_unsigned_divider
//   Multi-cycle restoring unsigned divider producing one quotient bit per clock.
//   quotient = floor(dividend / divisor), remainder = dividend mod divisor.
//
// Handshake (start / busy / done):
//   start is sampled only while the FSM is in IDLE or DONE; on that edge the
//   operands are latched and busy rises for the next DIVIDEND_W cycles. start
//   while busy is ignored. done is a registered one-cycle pulse in the DONE
//   cycle, from which quotient/remainder are valid; they hold until the next
//   accepted start completes. start in the DONE cycle is accepted back-to-back.
//
// Optional feature (macro DIVIDER_ZERO_CHECK_EN):
//   defined   : divisor 0 finishes after a single CALC cycle, quotient all ones,
//               remainder = dividend[DIVISOR_W-1:0], dbz = 1 until next start.
//   undefined : no dbz port; divisor 0 runs the full algorithm, which yields the
//               same quotient/remainder naturally.
//
// Ports
//   clk        in   1            system clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   start      in   1            request a division
//   dividend   in   DIVIDEND_W   unsigned dividend
//   divisor    in   DIVISOR_W    unsigned divisor
//   busy       out  1            division in progress
//   done       out  1            one-cycle completion pulse
//   quotient   out  DIVIDEND_W   result quotient
//   remainder  out  DIVISOR_W    result remainder
//   dbz        out  1            divide-by-zero flag (macro only)
//   dbg_state  out  state_e      current FSM state, for observation
// -----------------------------------------------------------------------------
module sequential_unsigned_divider
    import divider_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
`ifdef DIVIDER_ZERO_CHECK_EN
    output logic                  dbz,
`endif
    output state_e                dbg_state
);

    localparam int CNT_W = cnt_width(DIVIDEND_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [DIVIDEND_W-1:0] dvd_sr;   // dividend, shifted left; MSB feeds the step
    logic [DIVISOR_W-1:0]  dvs;      // latched divisor
    logic [DIVISOR_W:0]    pr;       // partial remainder
    logic [DIVIDEND_W-1:0] q_sr;     // quotient under construction, fills MSB-first

    logic [DIVISOR_W:0]    pr_next;
    logic                  q_bit;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .pr      (pr),
        .din     (dvd_sr[DIVIDEND_W-1]),
        .divisor (dvs),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            dvd_sr    <= '0;
            dvs       <= '0;
            pr        <= '0;
            q_sr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
            dbz       <= 1'b0;
`endif
        end else begin
            // done is a pulse: it is only raised on the edge entering DONE.
            done <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        dvd_sr <= dividend;
                        dvs    <= divisor;
                        pr     <= '0;
                        q_sr   <= '0;
                        cnt    <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
                        dbz    <= 1'b0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end

                CALC: begin
`ifdef DIVIDER_ZERO_CHECK_EN
                    // Divisor 0 is detected in the first CALC cycle and the
                    // fixed result is posted without running the steps.
                    if (dvs == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= '1;
                        remainder <= dvd_sr[DIVISOR_W-1:0];
                        dbz       <= 1'b1;
                    end else
`endif
                    begin
                        pr     <= pr_next;
                        q_sr   <= {q_sr[DIVIDEND_W-2:0], q_bit};
                        dvd_sr <= {dvd_sr[DIVIDEND_W-2:0], 1'b0};
                        cnt    <= cnt + 1'b1;
                        if (cnt == LAST_STEP) begin
                            // Results are taken straight from this final step so
                            // they appear in the same cycle as done.
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            quotient  <= {q_sr[DIVIDEND_W-2:0], q_bit};
                            remainder <= pr_next[DIVISOR_W-1:0];
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_unsigned_divider.sv
module tb_sequential_unsigned_divider;
    import divider_pkg::*;

    localparam int DW = 16;
    localparam int VW = 8;
    localparam int NORMAL_EDGES = DW + 1;
`ifdef DIVIDER_ZERO_CHECK_EN
    localparam int ZERO_EDGES = 2;
`else
    localparam int ZERO_EDGES = DW + 1;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    state_e        dbg_state;
`ifdef DIVIDER_ZERO_CHECK_EN
    logic          dbz;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    sequential_unsigned_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
`ifdef DIVIDER_ZERO_CHECK_EN
        .dbz       (dbz),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic void ref_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                                    output logic [DW-1:0] q, output logic [VW-1:0] r);
        if (b == 0) begin
            q = '1;
            r = a[VW-1:0];
        end else begin
            q = DW'(a / b);
            r = VW'(a % b);
        end
    endfunction

    // ---------------- driver ----------------
    // Issues start for one edge and waits for done. edges counts the start edge
    // as edge 1; returns in the done cycle (at a negedge), start low.
    task automatic run_div(input logic [DW-1:0] a, input logic [VW-1:0] b,
                           output int edges, output int busy_cycles, output bit ok);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        busy_cycles = busy ? 1 : 0;
        while (!done && edges < 40) begin
            @(negedge clk);
            edges++;
            if (busy) busy_cycles++;
        end
        ok = done;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #1;
        total_cnt++;
        if ({busy, done, quotient, remainder} !== '0)
            $display("FAIL reset_outputs busy=%0b done=%0b q=%0d r=%0d required all 0",
                     busy, done, quotient, remainder);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== IDLE) $display("FAIL reset_state got=%0d required=%0d", dbg_state, IDLE);
        else pass_cnt++;
`ifdef DIVIDER_ZERO_CHECK_EN
        total_cnt++;
        if (dbz !== 1'b0) $display("FAIL reset_dbz got=%0b required=0", dbz);
        else pass_cnt++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int edges, bc;
        bit ok;
        run_div(16'd200, 8'd7, edges, bc, ok);
        total_cnt++;
        if (!ok || edges !== NORMAL_EDGES) $display("FAIL basic_latency got=%0d required=%0d", edges, NORMAL_EDGES);
        else pass_cnt++;
        total_cnt++;
        if (bc !== DW) $display("FAIL basic_busy_cycles got=%0d required=%0d", bc, DW);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'd28 || remainder !== 8'd4)
            $display("FAIL basic_result got=%0d r %0d required=28 r 4", quotient, remainder);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || dbg_state !== IDLE)
            $display("FAIL basic_done_pulse done=%0b state=%0d required done=0 state=IDLE", done, dbg_state);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'd28 || remainder !== 8'd4)
            $display("FAIL basic_hold got=%0d r %0d required=28 r 4", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_extremes();
        int edges, bc;
        bit ok;
        run_div(16'd65535, 8'd255, edges, bc, ok);
        total_cnt++;
        if (!ok || quotient !== 16'd257 || remainder !== 8'd0)
            $display("FAIL max_operands got=%0d r %0d required=257 r 0", quotient, remainder);
        else pass_cnt++;
        run_div(16'd5, 8'd9, edges, bc, ok);
        total_cnt++;
        if (!ok || quotient !== 16'd0 || remainder !== 8'd5)
            $display("FAIL small_dividend got=%0d r %0d required=0 r 5", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_div_by_zero();
        int edges, bc;
        bit ok;
        run_div(16'd1000, 8'd0, edges, bc, ok);
        total_cnt++;
        if (!ok || edges !== ZERO_EDGES) $display("FAIL dbz_latency got=%0d required=%0d", edges, ZERO_EDGES);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'hFFFF || remainder !== 8'hE8)
            $display("FAIL dbz_result got=%h r %h required=ffff r e8", quotient, remainder);
        else pass_cnt++;
`ifdef DIVIDER_ZERO_CHECK_EN
        total_cnt++;
        if (dbz !== 1'b1) $display("FAIL dbz_flag got=%0b required=1", dbz);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if (dbz !== 1'b1) $display("FAIL dbz_hold got=%0b required=1", dbz);
        else pass_cnt++;
        run_div(16'd9, 8'd3, edges, bc, ok);
        total_cnt++;
        if (dbz !== 1'b0) $display("FAIL dbz_clear got=%0b required=0", dbz);
        else pass_cnt++;
`endif
    endtask

    task automatic test_start_while_busy();
        int edges;
        @(negedge clk);
        dividend = 16'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (!done && edges < 40) begin
            if (edges == 5) begin
                dividend = 16'd9;
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        total_cnt++;
        if (edges !== NORMAL_EDGES) $display("FAIL busy_start_latency got=%0d required=%0d", edges, NORMAL_EDGES);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'd28 || remainder !== 8'd4)
            $display("FAIL busy_start_ignored got=%0d r %0d required=28 r 4", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int edges, bc;
        bit ok;
        run_div(16'd200, 8'd7, edges, bc, ok);
        // still in the DONE cycle: request the next division
        dividend = 16'd9;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        total_cnt++;
        if (done !== 1'b0 || busy !== 1'b1)
            $display("FAIL b2b_accept done=%0b busy=%0b required done=0 busy=1", done, busy);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'd28 || remainder !== 8'd4)
            $display("FAIL b2b_hold_during_calc got=%0d r %0d required=28 r 4", quotient, remainder);
        else pass_cnt++;
        while (!done && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        total_cnt++;
        if (edges !== NORMAL_EDGES) $display("FAIL b2b_latency got=%0d required=%0d", edges, NORMAL_EDGES);
        else pass_cnt++;
        total_cnt++;
        if (quotient !== 16'd3 || remainder !== 8'd0)
            $display("FAIL b2b_result got=%0d r %0d required=3 r 0", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int edges, bc;
        bit ok;
        bit saw_done;
        @(negedge clk);
        dividend = 16'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, quotient, remainder} !== '0)
            $display("FAIL abort_outputs busy=%0b done=%0b q=%0d r=%0d required all 0",
                     busy, done, quotient, remainder);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== IDLE) $display("FAIL abort_state got=%0d required=%0d", dbg_state, IDLE);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        total_cnt++;
        if (saw_done !== 1'b0) $display("FAIL abort_no_done got=%0b required=0", saw_done);
        else pass_cnt++;
        run_div(16'd200, 8'd7, edges, bc, ok);
        total_cnt++;
        if (!ok || quotient !== 16'd28 || remainder !== 8'd4)
            $display("FAIL abort_recover got=%0d r %0d required=28 r 4", quotient, remainder);
        else pass_cnt++;
    endtask

    task automatic test_random(input int n);
        int edges, bc, exp_edges, mode;
        bit ok;
        logic [DW-1:0] a, exp_q;
        logic [VW-1:0] b, exp_r;
        for (int i = 0; i < n; i++) begin
            mode = $urandom_range(0, 9);
            a = DW'($urandom_range(0, 65535));
            case (mode)
                0: b = 8'd1;
                1: begin
                    b = VW'($urandom_range(1, 255));
                    a = DW'($urandom_range(0, int'(b) - 1));
                end
                2: b = (i % 4 == 0) ? 8'd0 : VW'($urandom_range(1, 15));
                default: b = VW'($urandom_range(1, 255));
            endcase
            ref_div(a, b, exp_q, exp_r);
            exp_edges = (b == 0) ? ZERO_EDGES : NORMAL_EDGES;
            run_div(a, b, edges, bc, ok);
            total_cnt++;
            if (!ok || edges !== exp_edges)
                $display("FAIL rand_latency %0d/%0d got=%0d required=%0d", a, b, edges, exp_edges);
            else pass_cnt++;
            total_cnt++;
            if (quotient !== exp_q || remainder !== exp_r)
                $display("FAIL rand_result %0d/%0d got=%0d r %0d required=%0d r %0d",
                         a, b, quotient, remainder, exp_q, exp_r);
            else pass_cnt++;
            if (b != 0) begin
                total_cnt++;
                if ((32'(quotient) * 32'(b) + 32'(remainder)) !== 32'(a) || remainder >= b)
                    $display("FAIL rand_identity %0d/%0d got q=%0d r=%0d", a, b, quotient, remainder);
                else pass_cnt++;
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_div_by_zero();
        test_start_while_busy();
        test_back_to_back();
        test_abort();
        test_random(1000);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
